// File: rtl/bus_cmd_sequencer.sv
// bus_cmd_sequencer: queued command initiator replaying func/Data slots of HOLD drive
// cycles followed by GAP idle cycles. Optional bus sampling: define BUS_CAPTURE_EN.
module bus_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 2
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_func,
  input  logic [7:0] req_data,
  output logic [2:0] func,
  output logic [7:0] Data,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] bus,
  output logic [7:0] cap_data,
  output logic       cap_valid
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2(MAXHG + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    func_reg, func_next;
  logic [7:0]    data_reg, data_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [10:0]   mem [DEPTH];
  logic [10:0]   head;
  logic          handshake, illegal, push, pop, slot_end, empty;
  logic          done_reg, err_reg;

  // Full blocks new requests even when a pop lands in the same cycle.
  assign req_ready = (count_reg != FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign handshake = req_valid && req_ready;
  assign illegal   = (req_func > 3'd5);
  assign push      = handshake && !illegal;
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_reg] <= {req_func, req_data};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    func_next  = func_reg;
    data_next  = data_reg;
    pop        = 1'b0;
    slot_end   = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_DRIVE;
          cnt_next   = HOLD_LOAD;
          pop        = 1'b1;
          func_next  = head[10:8];
          data_next  = head[7:0];
        end
      end
      S_DRIVE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (GAP > 0) begin
          state_next = S_GAP;
          cnt_next   = GAP_LOAD;
          func_next  = 3'd0;
        end else begin
          slot_end = 1'b1;
          if (!empty) begin
            cnt_next  = HOLD_LOAD;
            pop       = 1'b1;
            func_next = head[10:8];
            data_next = head[7:0];
          end else begin
            state_next = S_IDLE;
            func_next  = 3'd0;
          end
        end
      end
      S_GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          slot_end = 1'b1;
          if (!empty) begin
            state_next = S_DRIVE;
            cnt_next   = HOLD_LOAD;
            pop        = 1'b1;
            func_next  = head[10:8];
            data_next  = head[7:0];
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      func_reg   <= '0;
      data_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      func_reg  <= func_next;
      data_reg  <= data_next;
      done_reg  <= slot_end;
      err_reg   <= handshake && illegal;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign func = func_reg;
  assign Data = data_reg;
  assign busy = (state_reg != S_IDLE) || !empty;
  assign done = done_reg;
  assign err  = err_reg;

`ifdef BUS_CAPTURE_EN
  logic [7:0] cap_data_reg;
  logic       cap_valid_reg;
  logic       cap_now;

  // Sample on the final drive cycle of a move, while the source is still enabled.
  assign cap_now = (state_reg == S_DRIVE) && (cnt_reg == '0) &&
                   ((func_reg == 3'd1) || (func_reg == 3'd2));

  always_ff @(posedge Clock) begin
    if (!reset) begin
      cap_data_reg  <= '0;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_valid_reg <= cap_now;
      if (cap_now) cap_data_reg <= bus;
    end
  end

  assign cap_data  = cap_data_reg;
  assign cap_valid = cap_valid_reg;
`else
  logic unused_bus;
  assign unused_bus = ^bus;
  assign cap_data   = '0;
  assign cap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cmd_sequencer.sv
// Testbench for bus_cmd_sequencer: randomized requests checked against a slot-schedule model.
module tb_bus_cmd_sequencer;
  localparam int D = 4;
  localparam int H = 3;
  localparam int G = 2;

  logic       Clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [2:0] req_func, func;
  logic [7:0] req_data, Data, bus, cap_data;
  logic       busy, done, err, cap_valid;

  logic       f_valid, f_ready, f_busy, f_done, f_err, f_cap_valid;
  logic [2:0] f_func_in, f_func;
  logic [7:0] f_data_in, f_data, f_cap_data;
  logic [7:0] f_bus;

  always #5 Clock = ~Clock;

  bus_cmd_sequencer #(.DEPTH(D), .HOLD(H), .GAP(G)) dut (
    .Clock(Clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data(req_data), .func(func), .Data(Data),
    .busy(busy), .done(done), .err(err), .bus(bus), .cap_data(cap_data),
    .cap_valid(cap_valid)
  );

  bus_cmd_sequencer #(.DEPTH(4), .HOLD(1), .GAP(0)) dut_fast (
    .Clock(Clock), .reset(reset), .req_valid(f_valid), .req_ready(f_ready),
    .req_func(f_func_in), .req_data(f_data_in), .func(f_func), .Data(f_data),
    .busy(f_busy), .done(f_done), .err(f_err), .bus(f_bus), .cap_data(f_cap_data),
    .cap_valid(f_cap_valid)
  );

  typedef struct { bit v; logic [2:0] f; logic [7:0] d; } item_t;
  typedef struct { int a; int p; logic [2:0] f; logic [7:0] d; } slot_t;

  item_t      pend_q[$];
  slot_t      slots[$];
  int         ill_q[$];
  int         last_pop = -100;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         bus_random = 1'b1;
  logic [7:0] bus_const = 8'h00;
  logic [7:0] bus_hist [0:8191];

  // Model: a request accepted at edge a starts its slot at the later of a+1 and the
  // previous slot start plus HOLD+GAP; all outputs follow from those slot start edges.
  function automatic logic [2:0] m_func(int t);
    foreach (slots[i]) if (slots[i].p <= t && t < slots[i].p + H) return slots[i].f;
    return 3'd0;
  endfunction

  function automatic logic [7:0] m_data(int t);
    logic [7:0] r = 8'd0;
    foreach (slots[i]) if (slots[i].p <= t) r = slots[i].d;
    return r;
  endfunction

  function automatic logic m_done(int t);
    foreach (slots[i]) if (slots[i].p + H + G == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(int t);
    foreach (slots[i]) if (slots[i].a <= t && t < slots[i].p + H + G) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready(int t);
    int n = 0;
    foreach (slots[i]) if (slots[i].a <= t && t < slots[i].p) n++;
    return (n < D);
  endfunction

  function automatic logic m_err(int t);
    foreach (ill_q[i]) if (ill_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_capv(int t);
    logic r = 1'b0;
`ifdef BUS_CAPTURE_EN
    foreach (slots[i])
      if ((slots[i].f == 3'd1 || slots[i].f == 3'd2) && slots[i].p + H == t) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [7:0] m_capd(int t);
    logic [7:0] r = 8'd0;
`ifdef BUS_CAPTURE_EN
    foreach (slots[i])
      if ((slots[i].f == 3'd1 || slots[i].f == 3'd2) && slots[i].p + H <= t)
        r = bus_hist[slots[i].p + H - 1];
`endif
    return r;
  endfunction

  // One clock: drive head of pend_q, advance the edge index, update the model.
  task automatic step();
    item_t it;
    bit    have, acc;
    int    p;
    have = (pend_q.size() > 0);
    if (have) it = pend_q[0];
    else it = '{v: 1'b0, f: 3'd0, d: 8'd0};
    req_valid = it.v;
    req_func  = it.f;
    req_data  = it.d;
    bus = bus_random ? 8'($urandom) : bus_const;
    if (cyc < 8192) bus_hist[cyc] = bus;
    acc = it.v && reset && m_ready(cyc);
    @(posedge Clock);
    cyc++;
    if (!reset) begin
      slots.delete();
      ill_q.delete();
      last_pop = -100;
    end else if (acc) begin
      $display("req cyc=%0d func=%0d data=%02h", cyc, it.f, it.d);
      if (it.f > 3'd5) begin
        ill_q.push_back(cyc);
      end else begin
        p = (last_pop + H + G > cyc + 1) ? last_pop + H + G : cyc + 1;
        slots.push_back('{a: cyc, p: p, f: it.f, d: it.d});
        last_pop = p;
      end
    end
    if (have && (!it.v || acc)) void'(pend_q.pop_front());
    @(negedge Clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    checks += 8;
    if (func !== 3'd0) begin failures++; $display("FAIL reset_func got=%0d exp=0", func); end
    if (Data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", Data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    if (cap_valid !== 1'b0) begin failures++; $display("FAIL reset_capv got=%0b exp=0", cap_valid); end
    if (cap_data !== 8'd0) begin failures++; $display("FAIL reset_capd got=%0h exp=0", cap_data); end
    if (f_func !== 3'd0) begin failures++; $display("FAIL reset_ffunc got=%0d exp=0", f_func); end
    step();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_loads();
    pend_q.push_back('{v: 1'b1, f: 3'd3, d: 8'd1});
    pend_q.push_back('{v: 1'b1, f: 3'd4, d: 8'd2});
    pend_q.push_back('{v: 1'b1, f: 3'd5, d: 8'd3});
    for (int n = 0; n < 22; n++) begin
      checks += 4;
      if (func !== m_func(cyc)) begin failures++; $display("FAIL loads_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      if (Data !== m_data(cyc)) begin failures++; $display("FAIL loads_data cyc=%0d got=%0h exp=%0h", cyc, Data, m_data(cyc)); end
      if (done !== m_done(cyc)) begin failures++; $display("FAIL loads_done cyc=%0d got=%0b exp=%0b", cyc, done, m_done(cyc)); end
      if (busy !== m_busy(cyc)) begin failures++; $display("FAIL loads_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy(cyc)); end
      step();
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++)
      pend_q.push_back('{v: 1'b1, f: 3'($urandom_range(3, 5)), d: 8'($urandom)});
    for (int n = 0; n < 40; n++) begin
      checks += 4;
      if (req_ready !== m_ready(cyc)) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0b exp=%0b", cyc, req_ready, m_ready(cyc)); end
      if (func !== m_func(cyc)) begin failures++; $display("FAIL bp_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      if (Data !== m_data(cyc)) begin failures++; $display("FAIL bp_data cyc=%0d got=%0h exp=%0h", cyc, Data, m_data(cyc)); end
      if (done !== m_done(cyc)) begin failures++; $display("FAIL bp_done cyc=%0d got=%0b exp=%0b", cyc, done, m_done(cyc)); end
      step();
    end
  endtask

  task automatic test_illegal();
    pend_q.push_back('{v: 1'b1, f: 3'd7, d: 8'h5a});
    pend_q.push_back('{v: 1'b0, f: 3'd0, d: 8'h00});
    pend_q.push_back('{v: 1'b1, f: 3'd3, d: 8'h21});
    pend_q.push_back('{v: 1'b1, f: 3'd6, d: 8'h33});
    pend_q.push_back('{v: 1'b1, f: 3'd4, d: 8'h42});
    for (int n = 0; n < 20; n++) begin
      checks += 5;
      if (err !== m_err(cyc)) begin failures++; $display("FAIL ill_err cyc=%0d got=%0b exp=%0b", cyc, err, m_err(cyc)); end
      if (busy !== m_busy(cyc)) begin failures++; $display("FAIL ill_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy(cyc)); end
      if (req_ready !== m_ready(cyc)) begin failures++; $display("FAIL ill_ready cyc=%0d got=%0b exp=%0b", cyc, req_ready, m_ready(cyc)); end
      if (func !== m_func(cyc)) begin failures++; $display("FAIL ill_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      if (done !== m_done(cyc)) begin failures++; $display("FAIL ill_done cyc=%0d got=%0b exp=%0b", cyc, done, m_done(cyc)); end
      step();
    end
  endtask

  task automatic test_capture();
    bus_random = 1'b0;
    bus_const  = 8'h02;
    pend_q.push_back('{v: 1'b1, f: 3'd1, d: 8'h9c});
    pend_q.push_back('{v: 1'b1, f: 3'd5, d: 8'h04});
    for (int n = 0; n < 16; n++) begin
      checks += 3;
      if (cap_valid !== m_capv(cyc)) begin failures++; $display("FAIL cap_valid cyc=%0d got=%0b exp=%0b", cyc, cap_valid, m_capv(cyc)); end
      if (cap_data !== m_capd(cyc)) begin failures++; $display("FAIL cap_data cyc=%0d got=%0h exp=%0h", cyc, cap_data, m_capd(cyc)); end
      if (func !== m_func(cyc)) begin failures++; $display("FAIL cap_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      step();
    end
    bus_random = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) pend_q.push_back('{v: 1'b0, f: 3'd0, d: 8'd0});
      pend_q.push_back('{v: 1'b1, f: 3'($urandom_range(0, 7)), d: 8'($urandom)});
    end
    for (int n = 0; n < 1000; n++) begin
      if (pend_q.size() == 0 && !m_busy(cyc)) break;
      checks += 9;
      if (func !== m_func(cyc)) begin failures++; $display("FAIL rnd_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      if (Data !== m_data(cyc)) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, Data, m_data(cyc)); end
      if (done !== m_done(cyc)) begin failures++; $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", cyc, done, m_done(cyc)); end
      if (busy !== m_busy(cyc)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy(cyc)); end
      if (req_ready !== m_ready(cyc)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, req_ready, m_ready(cyc)); end
      if (err !== m_err(cyc)) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err, m_err(cyc)); end
      if (cap_valid !== m_capv(cyc)) begin failures++; $display("FAIL rnd_capv cyc=%0d got=%0b exp=%0b", cyc, cap_valid, m_capv(cyc)); end
      if (cap_data !== m_capd(cyc)) begin failures++; $display("FAIL rnd_capd cyc=%0d got=%0h exp=%0h", cyc, cap_data, m_capd(cyc)); end
      if (cap_data !== m_capd(cyc) && 1'b0) failures++;
      if (f_busy !== 1'b0) begin failures++; $display("FAIL rnd_fidle cyc=%0d got=%0b exp=0", cyc, f_busy); end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0b exp=0", busy); end
  endtask

  // HOLD=1, GAP=0 instance: consecutive loads change func every cycle, then back to 0.
  task automatic test_fast();
    checks++;
    if (f_ready !== 1'b1) begin failures++; $display("FAIL fast_ready got=%0b exp=1", f_ready); end
    f_valid = 1'b1; f_func_in = 3'd3; f_data_in = 8'h11;
    step();
    f_func_in = 3'd4; f_data_in = 8'h22;
    checks += 2;
    if (f_func !== 3'd0) begin failures++; $display("FAIL fast_func0 got=%0d exp=0", f_func); end
    if (f_busy !== 1'b1) begin failures++; $display("FAIL fast_busy0 got=%0b exp=1", f_busy); end
    step();
    f_valid = 1'b0;
    checks += 3;
    if (f_func !== 3'd3) begin failures++; $display("FAIL fast_func1 got=%0d exp=3", f_func); end
    if (f_data !== 8'h11) begin failures++; $display("FAIL fast_data1 got=%0h exp=11", f_data); end
    if (f_done !== 1'b0) begin failures++; $display("FAIL fast_done1 got=%0b exp=0", f_done); end
    step();
    checks += 3;
    if (f_func !== 3'd4) begin failures++; $display("FAIL fast_func2 got=%0d exp=4", f_func); end
    if (f_data !== 8'h22) begin failures++; $display("FAIL fast_data2 got=%0h exp=22", f_data); end
    if (f_done !== 1'b1) begin failures++; $display("FAIL fast_done2 got=%0b exp=1", f_done); end
    step();
    checks += 4;
    if (f_func !== 3'd0) begin failures++; $display("FAIL fast_func3 got=%0d exp=0", f_func); end
    if (f_data !== 8'h22) begin failures++; $display("FAIL fast_data3 got=%0h exp=22", f_data); end
    if (f_done !== 1'b1) begin failures++; $display("FAIL fast_done3 got=%0b exp=1", f_done); end
    if (f_busy !== 1'b0) begin failures++; $display("FAIL fast_busy3 got=%0b exp=0", f_busy); end
    step();
    checks++;
    if (f_done !== 1'b0) begin failures++; $display("FAIL fast_done4 got=%0b exp=0", f_done); end
  endtask

  task automatic test_reset_mid();
    pend_q.push_back('{v: 1'b1, f: 3'd3, d: 8'h71});
    pend_q.push_back('{v: 1'b1, f: 3'd4, d: 8'h72});
    pend_q.push_back('{v: 1'b1, f: 3'd5, d: 8'h73});
    repeat (3) step();
    checks += 2;
    if (func !== m_func(cyc)) begin failures++; $display("FAIL mid_pre_func got=%0d exp=%0d", func, m_func(cyc)); end
    if (busy !== m_busy(cyc)) begin failures++; $display("FAIL mid_pre_busy got=%0b exp=%0b", busy, m_busy(cyc)); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks += 5;
    if (func !== 3'd0) begin failures++; $display("FAIL mid_func got=%0d exp=0", func); end
    if (Data !== 8'd0) begin failures++; $display("FAIL mid_data got=%0h exp=0", Data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%0b exp=0", done); end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", req_ready); end
    for (int n = 0; n < 8; n++) begin
      step();
      checks += 3;
      if (func !== m_func(cyc)) begin failures++; $display("FAIL mid_after_func cyc=%0d got=%0d exp=%0d", cyc, func, m_func(cyc)); end
      if (done !== m_done(cyc)) begin failures++; $display("FAIL mid_after_done cyc=%0d got=%0b exp=%0b", cyc, done, m_done(cyc)); end
      if (busy !== m_busy(cyc)) begin failures++; $display("FAIL mid_after_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy(cyc)); end
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_func = 3'd0; req_data = 8'd0; bus = 8'd0;
    f_valid = 1'b0; f_func_in = 3'd0; f_data_in = 8'd0; f_bus = 8'd0;
    test_reset();
    test_loads();
    test_backpressure();
    test_illegal();
    test_capture();
    test_random();
    test_fast();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_cmd_sequencer.md
# bus_cmd_sequencer

Command initiator for the tri-state register bus. Accepts queued transfer requests (load register from immediate, register-to-register move) over a valid/ready interface and replays each one as a properly timed `func`/`Data` slot: the command is held for `HOLD` cycles, then followed by `GAP` idle cycles with `func`=0. It replaces hand-sequenced stimulus in front of the bus structure. It optionally samples the shared bus at the end of each move.

## Interface
- `DEPTH`, 4: command queue entries; power of two, ≥2.
- `HOLD`, 3: cycles each command is driven on `func`; ≥1.
- `GAP`, 2: idle cycles (`func`=0) after each command; ≥0.

- `Clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept; equals !full.
- `req_func`  in  3  0 NOP, 1 MOVE_A, 2 MOVE_B, 3 LOAD_R1, 4 LOAD_R2, 5 LOAD_R3; 6–7 illegal.
- `req_data`  in  8  immediate for loads; ignored otherwise.
- `func`  out  3  registered function code to the bus structure.
- `Data`  out  8  registered immediate to the bus structure.
- `busy`  out  1  state ≠ IDLE or queue non-empty.
- `done`  out  1  one-cycle pulse when a command's slot completes.
- `err`  out  1  one-cycle pulse when an illegal `req_func` is handshaked.
- `bus`  in  8  shared bus sample input (used only with the capture feature).
- `cap_data`  out  8  last captured bus value.
- `cap_valid`  out  1  one-cycle pulse on capture.

## Operation
- Handshake: transfer on the edge where `req_valid`&&`req_ready`. Codes 0–5 are written to the queue as {func, data}. Codes 6–7 are consumed without enqueue and pulse `err` next cycle.
- Queue: circular FIFO. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is log2(DEPTH)+1 bits. `req_ready`=0 when count==DEPTH, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full leave count unchanged.
- FSM states:
  - IDLE → DRIVE when the queue is non-empty. Pop the head and load it into `func`/`Data`.
  - DRIVE: hold for HOLD cycles.
    - Exit to GAP when GAP>0. `func`←0; `Data` keeps its value.
    - When GAP==0, exit to DRIVE (next pop) if the queue is non-empty, else to IDLE with `func`←0.
  - GAP: hold `func`=0 for GAP cycles, then go to DRIVE if the queue is non-empty, else IDLE.
- NOP (code 0) occupies a full slot: `func`=0 for HOLD+GAP cycles. It still pulses `done`.
- `done` pulses in the cycle after the slot's final cycle (last GAP cycle, or last DRIVE cycle when GAP==0).
- Slot counter: width log2(max(HOLD,GAP)+1). It reloads on every state entry.
- Reset (any state, mid-slot included):
  - Queue emptied, state IDLE.
  - `func`=0, `Data`=0.
  - `busy`/`done`/`err`/`cap_valid`=0, `cap_data`=0.
  - `req_ready`=1 the cycle after reset releases.

## Timing
- Empty queue and IDLE, request accepted at edge N: queue write at N, pop at N+1, `func` valid after N+1. First-command latency is 2 cycles.
- A command's `func` is stable for exactly HOLD cycles. Back-to-back slots are spaced HOLD+GAP cycles apart with no extra bubble.
- `err`, `done` and `cap_valid` are registered single-cycle pulses.

## Configuration
- `BUS_CAPTURE_EN` defined:
  - On the last DRIVE cycle of a MOVE_A/MOVE_B slot, `bus` is registered into `cap_data`.
  - `cap_valid` pulses in the following cycle.
  - Loads and NOP do not capture.
- Undefined: `bus` is ignored, and `cap_data`=0 and `cap_valid`=0 constantly. Ports stay present.

## Test plan
- Reset then LOAD_R1/1, LOAD_R2/2, LOAD_R3/3 pushed on consecutive cycles (defaults) → `func`=3,4,5, each for 3 cycles with 2 idle cycles between; `Data`=1,2,3; three `done` pulses; `busy` drops after the last gap.
- Push 5 requests with the sequencer stalled (DEPTH=4) → `req_ready`=0 after 4 entries; 5th is accepted only after the first pop; all 5 execute in order.
- `req_func`=7 → `err` pulses once, nothing executes, queue count unchanged.
- `BUS_CAPTURE_EN`: MOVE_A with `bus` driven 8'h02 on the last DRIVE cycle → `cap_data`=8'h02 and `cap_valid` pulse. LOAD_R3/4 → no capture.
- GAP=0, HOLD=1, two loads → `func` changes every cycle (3 then 4) with no zero between, then returns to 0.
- `reset` asserted mid-DRIVE with 2 entries queued → next cycle `func`=0, `busy`=0, queue empty; no `done` pulse.
